// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one I/O handler port among NUM_REQ masters, one transaction at a time.
// Optional transaction locking for atomic read-modify-write is enabled with `define IO_ARB_LOCK_EN.
module io_bus_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef IO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         io_addr,
    output logic                      io_write,
    output logic                      io_read,
    output logic [DATA_W-1:0]         io_wdata,
    input  logic [DATA_W-1:0]         io_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last;
    logic               is_write;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] last_onehot;
    logic               found;
    logic [IDX_W-1:0]   win;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k]  = req_addr[k*ADDR_W +: ADDR_W];
        assign wdata_arr[k] = req_wdata[k*DATA_W +: DATA_W];
    end

    always_comb begin
        last_onehot       = '0;
        last_onehot[last] = 1'b1;
    end

`ifdef IO_ARB_LOCK_EN
    // Lock owner is always the most recent winner, so 'last' doubles as the owner index.
    logic       locked;
    logic [1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            idle_cnt <= 2'd0;
        end else if (state == ISSUE) begin
            locked   <= req_lock[last];
            idle_cnt <= 2'd0;
        end else if (state == IDLE && locked) begin
            if (req[last]) begin
                idle_cnt <= 2'd0;
            end else if (idle_cnt == 2'd3) begin
                locked   <= 1'b0;
                idle_cnt <= 2'd0;
            end else begin
                idle_cnt <= idle_cnt + 2'd1;
            end
        end
    end

    assign eligible = locked ? (req & last_onehot) : req;
`else
    assign eligible = req;
`endif

    // Scan last+1, last+2, ... with wrap-around; first eligible requester wins.
    always_comb begin : arb_scan
        int               idx;
        logic [IDX_W-1:0] cand;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        win   = last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDX_W'(idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = is_write ? IDLE : RDWAIT;
            RDWAIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt      = (state == ISSUE) ? last_onehot : '0;
    assign io_write = (state == ISSUE) && is_write;
    assign io_read  = (state == ISSUE) && !is_write;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last     <= IDX_W'(NUM_REQ - 1);
            is_write <= 1'b0;
            io_addr  <= '0;
            io_wdata <= '0;
            rdata    <= '0;
            rvalid   <= '0;
        end else begin
            state  <= state_nxt;
            rvalid <= '0;
            if (state == IDLE && found) begin
                last     <= win;
                is_write <= req_we[win];
                io_addr  <= addr_arr[win];
                io_wdata <= wdata_arr[win];
            end
            // Handler data is valid during RDWAIT; capture it and flag the owner for one cycle.
            if (state == RDWAIT) begin
                rdata  <= io_rdata;
                rvalid <= last_onehot;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
// The lock scenario is compiled only when IO_ARB_LOCK_EN is defined.
module tb_io_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [AW-1:0]   io_addr;
    logic            io_write;
    logic            io_read;
    logic [DW-1:0]   io_wdata;
    logic [DW-1:0]   io_rdata;
`ifdef IO_ARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif

    always #5 clk = ~clk;

    io_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef IO_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .io_addr   (io_addr),
        .io_write  (io_write),
        .io_read   (io_read),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    // Handler stand-in: 16-word register file with one-cycle registered read data.
    logic [DW-1:0] hmem [16] = '{4: 32'h0000_003C, default: 32'hDEAD_0000};
    int            n_io_reads = 0;
    initial io_rdata = '0;
    always @(posedge clk) begin
        if (io_write) hmem[io_addr[3:0]] <= io_wdata;
        if (io_read) begin
            io_rdata   <= hmem[io_addr[3:0]];
            n_io_reads <= n_io_reads + 1;
        end
    end

    // Reference model state
    logic [DW-1:0] mmem [16] = '{4: 32'h0000_003C, default: 32'hDEAD_0000};
    logic [DW-1:0] exp_q[$];
    int            rd_cyc_q[$];
    int            rd_who_q[$];
    int            prio_q[$];
    int            cyc, next_ok, n_model_reads;
    logic [N-1:0]  exp_gnt, exp_rv;
    logic          exp_wr, exp_rd;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;
    int            wait_tx [N];
    int            mode;
    bit            model_on;
    int            n_assert, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Priority list: front is highest priority; the winner moves to the back.
    function automatic int pick_rotate();
        int j, w;
        j = -1;
        for (int i = 0; i < N; i++) if (j < 0 && req[prio_q[i]]) j = i;
        w = prio_q[j];
        for (int i = 0; i <= j; i++) prio_q.push_back(prio_q.pop_front());
        return w;
    endfunction

    task automatic model_reset();
        prio_q.delete();
        for (int i = 0; i < N; i++) prio_q.push_back(i);
        exp_q.delete();
        rd_cyc_q.delete();
        rd_who_q.delete();
        next_ok   = cyc;
        exp_gnt   = '0;
        exp_rv    = '0;
        exp_wr    = 1'b0;
        exp_rd    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
    endtask

    task automatic new_txn(input int k, input logic we, input logic [3:0] a);
        req[k]              = 1'b1;
        req_we[k]           = we;
        req_addr[k*AW +: AW]  = {28'h0, a};
        req_wdata[k*DW +: DW] = $urandom;
        wait_tx[k]          = 0;
    endtask

    task automatic retire(input int k);
        if (mode == 0) req[k] = 1'b0;
        else if (mode == 1) new_txn(k, 1'b1, {1'b1, 3'($urandom_range(0, 7))});
        else if ($urandom_range(0, 1) == 1) new_txn(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        else req[k] = 1'b0;
    endtask

    // One clock: model acceptance at the edge, compare at the falling edge, then requesters react.
    task automatic tick();
        int w;
        @(posedge clk);
        cyc++;
        exp_gnt = '0;
        exp_rv  = '0;
        exp_wr  = 1'b0;
        exp_rd  = 1'b0;
        if (rd_cyc_q.size() > 0 && rd_cyc_q[0] == cyc) begin
            void'(rd_cyc_q.pop_front());
            exp_rv    = onehot(rd_who_q.pop_front());
            exp_rdata = exp_q.pop_front();
        end
        if (cyc >= next_ok && req != '0) begin
            w         = pick_rotate();
            exp_gnt   = onehot(w);
            exp_addr  = req_addr[w*AW +: AW];
            exp_wdata = req_wdata[w*DW +: DW];
            if (req_we[w]) begin
                exp_wr                = 1'b1;
                mmem[exp_addr[3:0]]   = exp_wdata;
                next_ok               = cyc + 2;
            end else begin
                exp_rd = 1'b1;
                exp_q.push_back(mmem[exp_addr[3:0]]);
                rd_cyc_q.push_back(cyc + 2);
                rd_who_q.push_back(w);
                next_ok = cyc + 3;
                n_model_reads++;
            end
        end
        @(negedge clk);
        if (model_on) begin
            chk("gnt", gnt, exp_gnt);
            chk("io_write", io_write, exp_wr);
            chk("io_read", io_read, exp_rd);
            chk("rvalid", rvalid, exp_rv);
            chk("busy", busy, cyc < next_ok - 1);
            chk("io_addr", io_addr, exp_addr);
            chk("io_wdata", io_wdata, exp_wdata);
            if (exp_rv != '0) chk("rdata", rdata, exp_rdata);
        end
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                if (mode == 2) chk("fairness", wait_tx[k] <= N - 1, 1'b1);
                wait_tx[k] = 0;
            end else if (req[k] && gnt != '0) begin
                wait_tx[k]++;
            end
        end
        for (int k = 0; k < N; k++) if (gnt[k]) retire(k);
    endtask

    // Called at a falling edge; asserts reset asynchronously, checks, then releases.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, '0);
        chk("rst_rvalid", rvalid, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_io_read", io_read, 1'b0);
        chk("rst_io_write", io_write, 1'b0);
        chk("rst_io_addr", io_addr, '0);
        chk("rst_io_wdata", io_wdata, '0);
        chk("rst_rdata", rdata, '0);
        req = '0;
`ifdef IO_ARB_LOCK_EN
        req_lock = '0;
`endif
        @(posedge clk);
        cyc++;
        model_reset();
        @(negedge clk);
        chk("rst_hold_rvalid", rvalid, '0);
        chk("rst_hold_busy", busy, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        n_model_reads = 0;
        cyc           = 0;
        mode          = 0;
        model_on      = 1'b1;
        req           = '0;
        req_we        = '0;
        req_addr      = '0;
        req_wdata     = '0;
`ifdef IO_ARB_LOCK_EN
        req_lock      = '0;
`endif
        for (int k = 0; k < N; k++) wait_tx[k] = 0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Round-robin: all three hold write requests continuously.
        begin
            int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
            int s = 0;
            mode = 1;
            for (int k = 0; k < N; k++) new_txn(k, 1'b1, {1'b1, 3'(k)});
            for (int t = 0; t < 12; t++) begin
                tick();
                if (gnt != '0 && s < 6) begin
                    chk("rr_order", gnt, onehot(exp_seq[s]));
                    s++;
                end
            end
            chk("rr_grant_count", s, 6);
            mode = 0;
            req  = '0;
        end

        // Mixed: read from 0 and write from 2 raised together.
        new_txn(0, 1'b0, 4'h8);
        new_txn(2, 1'b1, 4'h2);
        tick();
        chk("mix_gnt_rd", gnt, 3'b001);
        chk("mix_io_read", io_read, 1'b1);
        tick();
        chk("mix_no_overlap", {io_read, io_write}, 2'b00);
        tick();
        chk("mix_rvalid", rvalid, 3'b001);
        tick();
        chk("mix_gnt_wr", gnt, 3'b100);
        chk("mix_io_write", {io_read, io_write}, 2'b01);
        tick();

        // Single write from requester 1.
        new_txn(1, 1'b1, 4'h5);
        req_wdata[1*DW +: DW] = 32'h0000_00A5;
        tick();
        chk("wr_gnt", gnt, 3'b010);
        chk("wr_io_write", io_write, 1'b1);
        chk("wr_io_addr", io_addr, 32'h5);
        chk("wr_io_wdata", io_wdata, 32'hA5);
        tick();
        chk("wr_busy_after", busy, 1'b0);
        chk("wr_addr_hold", io_addr, 32'h5);

        // Single read from requester 0 of address 4.
        new_txn(0, 1'b0, 4'h4);
        tick();
        chk("rd_io_read", io_read, 1'b1);
        chk("rd_gnt", gnt, 3'b001);
        tick();
        chk("rd_io_read_1cyc", io_read, 1'b0);
        tick();
        chk("rd_rvalid", rvalid, 3'b001);
        chk("rd_rdata", rdata, 32'h3C);
        tick();

        // Reset while a read sits in RDWAIT.
        new_txn(0, 1'b0, 4'h6);
        tick();
        tick();
        chk("midrd_busy_before", busy, 1'b1);
        do_reset();
        for (int k = 0; k < N; k++) new_txn(k, 1'b1, 4'($urandom_range(0, 15)));
        tick();
        chk("midrd_first_winner", gnt, 3'b001);
        for (int t = 0; t < 6; t++) tick();

`ifdef IO_ARB_LOCK_EN
        // Locked read-modify-write by requester 1 while requester 0 waits.
        do_reset();
        model_on = 1'b0;
        new_txn(1, 1'b0, 4'h8);
        req_lock = 3'b010;
        tick();
        chk("lock_rd_gnt", gnt, 3'b010);
        new_txn(1, 1'b1, 4'h8);
        new_txn(0, 1'b1, 4'h9);
        tick();
        req_lock = 3'b000;
        tick();
        chk("lock_rvalid", rvalid, 3'b010);
        tick();
        chk("lock_wr_first", gnt, 3'b010);
        tick();
        tick();
        chk("lock_released", gnt, 3'b001);
        tick();
        do_reset();
        model_on = 1'b1;
`endif

        // Random traffic.
        mode = 2;
        for (int t = 0; t < 600; t++) begin
            tick();
            for (int k = 0; k < N; k++)
                if (!req[k] && $urandom_range(0, 3) == 0)
                    new_txn(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        mode = 0;
        for (int t = 0; t < 12; t++) tick();
        req = '0;
        for (int t = 0; t < 4; t++) tick();
        chk("reads_issued_once", n_io_reads, n_model_reads);
        chk("rd_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
